// File: rtl/ptw_arb_pkg.sv
// Shared defaults and types for the PTW request arbiter.
// Included by the arbiter top, its pick sub-module and the bench.
package ptw_arb_pkg;

    localparam int DEF_NUM_IN   = 4;
    localparam int DEF_VPN_W    = 27;
    localparam int DEF_SRC_W    = 2;
    localparam int DEF_STARVE_W = 4;
    localparam int DEF_IDX_W    = $clog2(DEF_NUM_IN);

    typedef struct packed {
        logic [DEF_VPN_W-1:0] vpn;
        logic [DEF_SRC_W-1:0] source;
    } ptw_req_t;

endpackage

// File: rtl/ptw_arb_pick.sv
// Rotate-priority encoder: first set request at or after 'start',
// wrapping to index 0. Returns a one-hot grant and its encoded index.
module ptw_arb_pick
    import ptw_arb_pkg::*;
#(
    parameter  int NUM_IN = DEF_NUM_IN,
    localparam int IDX_W  = $clog2(NUM_IN)
) (
    input  logic [NUM_IN-1:0] req,
    input  logic [IDX_W-1:0]  start,
    output logic [NUM_IN-1:0] grant,
    output logic [IDX_W-1:0]  index
);

    always_comb begin
        logic             found;
        int               pos;
        logic [IDX_W-1:0] pos_idx;
        grant   = '0;
        index   = '0;
        found   = 1'b0;
        pos     = 0;
        pos_idx = '0;
        for (int k = 0; k < NUM_IN; k++) begin
            pos = int'(start) + k;
            if (pos >= NUM_IN) begin
                pos = pos - NUM_IN;
            end
            pos_idx = IDX_W'(pos);
            if (!found && req[pos_idx]) begin
                found          = 1'b1;
                grant[pos_idx] = 1'b1;
                index          = pos_idx;
            end
        end
    end

endmodule

// File: rtl/ptw_req_arbiter.sv
// N-channel PTW request arbiter: fixed-priority with starvation promotion or
// round-robin, feeding a single registered output entry with synchronous flush.
module ptw_req_arbiter
    import ptw_arb_pkg::*;
#(
    parameter  int NUM_IN   = DEF_NUM_IN,
    parameter  int VPN_W    = DEF_VPN_W,
    parameter  int SRC_W    = DEF_SRC_W,
    parameter  int STARVE_W = DEF_STARVE_W,
    localparam int IDX_W    = $clog2(NUM_IN)
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    io_mode,
    input  logic                    io_flush,
    input  logic [NUM_IN-1:0]       io_in_valid,
    output logic [NUM_IN-1:0]       io_in_ready,
    input  logic [NUM_IN*VPN_W-1:0] io_in_vpn,
    input  logic [NUM_IN*SRC_W-1:0] io_in_source,
    output logic                    io_out_valid,
    input  logic                    io_out_ready,
    output logic [VPN_W-1:0]        io_out_vpn,
    output logic [SRC_W-1:0]        io_out_source,
    output logic [IDX_W-1:0]        io_out_chosen
);

    localparam logic [STARVE_W-1:0] STARVE_MAX = '1;

    logic [IDX_W-1:0]    ptr;
    logic [STARVE_W-1:0] starve_cnt [NUM_IN];
    logic [NUM_IN-1:0]   starved;
    logic [NUM_IN-1:0]   starved_req;
    logic [NUM_IN-1:0]   fix_grant, rr_grant, stv_grant, grant, hs;
    logic [IDX_W-1:0]    fix_idx, rr_idx, stv_idx, win_idx;
    logic                accept;
    logic                hs_any;
    logic [VPN_W-1:0]    sel_vpn;
    logic [SRC_W-1:0]    sel_source;

    always_comb begin
        starved = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            starved[i] = (starve_cnt[i] == STARVE_MAX);
        end
    end

    assign starved_req = starved & io_in_valid;

    ptw_arb_pick #(.NUM_IN(NUM_IN)) u_pick_fix (
        .req   (io_in_valid),
        .start ('0),
        .grant (fix_grant),
        .index (fix_idx)
    );

    ptw_arb_pick #(.NUM_IN(NUM_IN)) u_pick_rr (
        .req   (io_in_valid),
        .start (ptr),
        .grant (rr_grant),
        .index (rr_idx)
    );

    ptw_arb_pick #(.NUM_IN(NUM_IN)) u_pick_starved (
        .req   (starved_req),
        .start ('0),
        .grant (stv_grant),
        .index (stv_idx)
    );

    // Starved channels only pre-empt the grant in fixed mode.
    always_comb begin
        grant   = fix_grant;
        win_idx = fix_idx;
        if (io_mode) begin
            grant   = rr_grant;
            win_idx = rr_idx;
        end else if (|starved_req) begin
            grant   = stv_grant;
            win_idx = stv_idx;
        end
    end

    assign accept      = ~io_flush & (~io_out_valid | io_out_ready);
    assign io_in_ready = grant & {NUM_IN{accept}};
    assign hs          = io_in_valid & io_in_ready;
    assign hs_any      = |hs;
    assign sel_vpn     = io_in_vpn[int'(win_idx) * VPN_W +: VPN_W];
    assign sel_source  = io_in_source[int'(win_idx) * SRC_W +: SRC_W];

    // A drain with no refill empties the stage; so does a flush, since a flush blocks refill.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            io_out_valid  <= 1'b0;
            io_out_vpn    <= '0;
            io_out_source <= '0;
            io_out_chosen <= '0;
        end else if (hs_any) begin
            io_out_valid  <= 1'b1;
            io_out_vpn    <= sel_vpn;
            io_out_source <= sel_source;
            io_out_chosen <= win_idx;
        end else if (io_flush || io_out_ready) begin
            io_out_valid  <= 1'b0;
        end
    end

    // The pointer advances in both modes so a mode switch stays fair.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ptr <= '0;
        end else if (hs_any) begin
            ptr <= (win_idx == IDX_W'(NUM_IN - 1)) ? '0 : win_idx + 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_IN; i++) begin
                starve_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_IN; i++) begin
                if (io_flush || !io_in_valid[i] || hs[i]) begin
                    starve_cnt[i] <= '0;
                end else if (starve_cnt[i] != STARVE_MAX) begin
                    starve_cnt[i] <= starve_cnt[i] + 1'b1;
                end
            end
        end
    end

endmodule
